// File: rtl/awp_step_counter.sv
// awp_step_counter: parametrised step counter for the AWP sequencer.
// It has manual up/down stepping, load and clear in IDLE, wrap or saturate arithmetic,
// and an autonomous RUN mode. RUN steps toward a terminal value and pulses done when it
// gets there. Vectors are numbered [0:WIDTH-1], so bit 0 is the MSB, as in the CPU registers.
module awp_step_counter #(
    parameter int unsigned WIDTH     = 6,  // 2..16
    parameter int unsigned SATURATE  = 0,  // 0: modulo wrap, 1: clamp at 0 / all-ones
    parameter int unsigned RUN_DOWN  = 1,  // 1: RUN decrements toward 0, 0: increments toward all-ones
    parameter int unsigned RESET_VAL = 0   // out value after rst
) (
    input  logic             clk_sys_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [0:WIDTH-1] in_i,
    input  logic             cda_i,
    input  logic             cua_i,
    input  logic             start_i,
    output logic [0:WIDTH-1] out_o,
    output logic             zero_o,
    output logic             ones_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             ovf_o
);

    localparam logic [0:WIDTH-1] ZERO     = '0;
    localparam logic [0:WIDTH-1] ALL_ONES = '1;
    localparam logic [0:WIDTH-1] ONE      = WIDTH'(1);
    localparam logic [0:WIDTH-1] RST_VAL  = WIDTH'(RESET_VAL);
    localparam logic [0:WIDTH-1] TERM     = (RUN_DOWN != 0) ? ZERO : ALL_ONES;
    localparam bit               SAT      = (SATURATE != 0);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q;
    logic [0:WIDTH-1] out_q;
    logic             busy_q;
    logic             done_q;
    logic             ovf_q;

    // Candidate next values for the counter, selected in the sequential block.
    logic [0:WIDTH-1] dec_raw;
    logic [0:WIDTH-1] inc_raw;
    logic             at_zero;
    logic             at_ones;
    logic [0:WIDTH-1] man_dec_d;
    logic [0:WIDTH-1] man_inc_d;
    logic [0:WIDTH-1] run_step_d;
    logic             run_last;
    logic             start_at_term;
    logic             step_dn;
    logic             step_up;

    // Step arithmetic: wrap or clamp for manual steps. A RUN step never leaves range
    // because the run stops at TERM.
    always_comb begin
        dec_raw       = out_q - ONE;
        inc_raw       = out_q + ONE;
        at_zero       = (out_q == ZERO);
        at_ones       = (out_q == ALL_ONES);
        man_dec_d     = (at_zero && SAT) ? out_q : dec_raw;
        man_inc_d     = (at_ones && SAT) ? out_q : inc_raw;
        run_step_d    = (RUN_DOWN != 0) ? dec_raw : inc_raw;
        run_last      = (run_step_d == TERM);
        start_at_term = (out_q == TERM);
        step_dn       = cda_i && !cua_i;
        step_up       = cua_i && !cda_i;
    end

    // Control FSM with registered outputs. done defaults low and is set only on the edge
    // that ends a run (or on a zero-length start).
    always_ff @(posedge clk_sys_i) begin
        done_q <= 1'b0;
        if (rst_i) begin
            state_q <= StIdle;
            out_q   <= RST_VAL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (clr_i) begin
            // clr aborts a run silently: no done pulse.
            state_q <= StIdle;
            out_q   <= ZERO;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (load_i) begin
                        out_q <= in_i;
                        ovf_q <= 1'b0;
                    end else if (start_i) begin
                        if (start_at_term) begin
                            // Zero-length loop: report completion without entering RUN.
                            done_q <= 1'b1;
                        end else begin
                            state_q <= StRun;
                            busy_q  <= 1'b1;
                        end
                    end else if (step_dn) begin
                        out_q <= man_dec_d;
                        if (at_zero) begin
                            ovf_q <= 1'b1;
                        end
                    end else if (step_up) begin
                        out_q <= man_inc_d;
                        if (at_ones) begin
                            ovf_q <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    // load/start/cda/cua are ignored while busy.
                    out_q <= run_step_d;
                    if (run_last) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Output mapping; zero/ones are the only combinational flags.
    always_comb begin
        out_o  = out_q;
        zero_o = (out_q == ZERO);
        ones_o = (out_q == ALL_ONES);
        busy_o = busy_q;
        done_o = done_q;
        ovf_o  = ovf_q;
    end

endmodule

// File: tb/tb_awp_step_counter.sv
// Directed bench for awp_step_counter. Two instances share stimulus:
// u_a is wrap mode, runs down, RESET_VAL=5; u_b is saturate mode, runs up, RESET_VAL=0.
module tb_awp_step_counter;

    localparam int unsigned W = 6;

    logic         clk;
    logic         rst;
    logic         clr;
    logic         load;
    logic [0:W-1] din;
    logic         cda;
    logic         cua;
    logic         start;

    logic [0:W-1] a_out;
    logic         a_zero;
    logic         a_ones;
    logic         a_busy;
    logic         a_done;
    logic         a_ovf;
    logic [0:W-1] b_out;
    logic         b_zero;
    logic         b_ones;
    logic         b_busy;
    logic         b_done;
    logic         b_ovf;

    int n_total = 0;
    int n_bad   = 0;

    awp_step_counter #(
        .WIDTH    (W),
        .SATURATE (0),
        .RUN_DOWN (1),
        .RESET_VAL(5)
    ) u_a (
        .clk_sys_i(clk),
        .rst_i    (rst),
        .clr_i    (clr),
        .load_i   (load),
        .in_i     (din),
        .cda_i    (cda),
        .cua_i    (cua),
        .start_i  (start),
        .out_o    (a_out),
        .zero_o   (a_zero),
        .ones_o   (a_ones),
        .busy_o   (a_busy),
        .done_o   (a_done),
        .ovf_o    (a_ovf)
    );

    awp_step_counter #(
        .WIDTH    (W),
        .SATURATE (1),
        .RUN_DOWN (0),
        .RESET_VAL(0)
    ) u_b (
        .clk_sys_i(clk),
        .rst_i    (rst),
        .clr_i    (clr),
        .load_i   (load),
        .in_i     (din),
        .cda_i    (cda),
        .cua_i    (cua),
        .start_i  (start),
        .out_o    (b_out),
        .zero_o   (b_zero),
        .ones_o   (b_ones),
        .busy_o   (b_busy),
        .done_o   (b_done),
        .ovf_o    (b_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    // One clock edge, then sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; clr = 0; load = 0; cda = 0; cua = 0; start = 0;
    endtask

    task automatic do_load(input int v);
        load = 1; din = W'(v);
        tick();
        load = 0;
    endtask

    task automatic do_start();
        start = 1;
        tick();
        start = 0;
    endtask

    initial begin
        idle_inputs();
        din = '0;
        rst = 1;
        tick();
        // 1. reset state
        check_eq("rst_a_out", 32'(a_out), 5);
        check_eq("rst_a_busy", 32'(a_busy), 0);
        check_eq("rst_a_done", 32'(a_done), 0);
        check_eq("rst_a_ovf", 32'(a_ovf), 0);
        check_eq("rst_b_out", 32'(b_out), 0);
        rst = 0;
        clr = 1;
        tick();
        clr = 0;
        check_eq("clr_out", 32'(a_out), 0);
        check_eq("clr_zero", 32'(a_zero), 1);
        check_eq("clr_ones", 32'(a_ones), 0);

        // 2. run down from 3
        do_load(3);
        check_eq("ld3_out", 32'(a_out), 3);
        do_start();
        check_eq("run_e0_out", 32'(a_out), 3);
        check_eq("run_e0_busy", 32'(a_busy), 1);
        check_eq("run_e0_done", 32'(a_done), 0);
        tick();
        check_eq("run_e1_out", 32'(a_out), 2);
        check_eq("run_e1_done", 32'(a_done), 0);
        tick();
        check_eq("run_e2_out", 32'(a_out), 1);
        check_eq("run_e2_busy", 32'(a_busy), 1);
        tick();
        check_eq("run_e3_out", 32'(a_out), 0);
        check_eq("run_e3_busy", 32'(a_busy), 0);
        check_eq("run_e3_done", 32'(a_done), 1);
        check_eq("run_e3_zero", 32'(a_zero), 1);
        tick();
        check_eq("run_e4_done", 32'(a_done), 0);
        check_eq("run_e4_out", 32'(a_out), 0);

        // 3. zero-length run (down)
        do_load(0);
        do_start();
        check_eq("zl_busy", 32'(a_busy), 0);
        check_eq("zl_done", 32'(a_done), 1);
        check_eq("zl_out", 32'(a_out), 0);
        tick();
        check_eq("zl_done_low", 32'(a_done), 0);

        // 4. wrap mode
        cda = 1;
        tick();
        cda = 0;
        check_eq("wrap_dn_out", 32'(a_out), 63);
        check_eq("wrap_dn_ovf", 32'(a_ovf), 1);
        check_eq("wrap_dn_ones", 32'(a_ones), 1);
        cua = 1;
        tick();
        cua = 0;
        check_eq("wrap_up_out", 32'(a_out), 0);
        check_eq("wrap_up_ovf", 32'(a_ovf), 1);
        do_load(7);
        check_eq("ld7_out", 32'(a_out), 7);
        check_eq("ld7_ovf", 32'(a_ovf), 0);

        // 5. priority / combination cases
        cda = 1; cua = 1;
        tick();
        cda = 0; cua = 0;
        check_eq("both_hold", 32'(a_out), 7);
        load = 1; clr = 1; din = W'(9);
        tick();
        load = 0; clr = 0;
        check_eq("ld_clr_out", 32'(a_out), 0);
        load = 1; start = 1; din = W'(12);
        tick();
        load = 0; start = 0;
        check_eq("ld_st_out", 32'(a_out), 12);
        check_eq("ld_st_busy", 32'(a_busy), 0);
        tick();
        check_eq("ld_st_busy2", 32'(a_busy), 0);
        check_eq("ld_st_out2", 32'(a_out), 12);

        // 6. mid-run clr
        do_load(20);
        do_start();
        check_eq("m_busy", 32'(a_busy), 1);
        clr = 1;
        tick();
        clr = 0;
        check_eq("m_clr_out", 32'(a_out), 0);
        check_eq("m_clr_busy", 32'(a_busy), 0);
        check_eq("m_clr_done", 32'(a_done), 0);
        tick();
        check_eq("m_clr_done2", 32'(a_done), 0);
        // inputs ignored while busy
        do_load(20);
        do_start();
        tick();
        check_eq("m_step_out", 32'(a_out), 19);
        cda = 1; load = 1; start = 1; din = W'(5);
        tick();
        cda = 0; load = 0; start = 0;
        check_eq("m_ign_out", 32'(a_out), 18);
        check_eq("m_ign_busy", 32'(a_busy), 1);
        // rst mid-run
        rst = 1;
        tick();
        rst = 0;
        check_eq("m_rst_out", 32'(a_out), 5);
        check_eq("m_rst_busy", 32'(a_busy), 0);
        check_eq("m_rst_done", 32'(a_done), 0);
        tick();
        check_eq("m_rst_done2", 32'(a_done), 0);
        check_eq("m_rst_out2", 32'(a_out), 5);

        // B instance: saturate, run up
        rst = 1;
        tick();
        rst = 0;
        check_eq("b_rst_out", 32'(b_out), 0);
        do_load(63);
        do_start();
        check_eq("b_zl_busy", 32'(b_busy), 0);
        check_eq("b_zl_done", 32'(b_done), 1);
        check_eq("b_zl_out", 32'(b_out), 63);
        tick();
        check_eq("b_zl_done2", 32'(b_done), 0);
        do_load(60);
        do_start();
        check_eq("b_run_e0", 32'(b_out), 60);
        check_eq("b_run_busy", 32'(b_busy), 1);
        tick();
        check_eq("b_run_e1", 32'(b_out), 61);
        tick();
        check_eq("b_run_e2", 32'(b_out), 62);
        check_eq("b_run_e2_done", 32'(b_done), 0);
        tick();
        check_eq("b_run_e3", 32'(b_out), 63);
        check_eq("b_run_e3_done", 32'(b_done), 1);
        check_eq("b_run_e3_busy", 32'(b_busy), 0);
        check_eq("b_run_ovf", 32'(b_ovf), 0);
        clr = 1;
        tick();
        clr = 0;
        cda = 1;
        tick();
        cda = 0;
        check_eq("b_sat_dn_out", 32'(b_out), 0);
        check_eq("b_sat_dn_ovf", 32'(b_ovf), 1);
        check_eq("b_sat_dn_zero", 32'(b_zero), 1);
        do_load(63);
        check_eq("b_ld_ovf", 32'(b_ovf), 0);
        cua = 1;
        tick();
        cua = 0;
        check_eq("b_sat_up_out", 32'(b_out), 63);
        check_eq("b_sat_up_ovf", 32'(b_ovf), 1);
        check_eq("b_sat_up_ones", 32'(b_ones), 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
